// File: rtl/otter_pkg.sv
// Shared OTTER types: PC source encoding, fetch FSM states, reset vector.
package otter_pkg;

  typedef enum logic [2:0] {
    PC_SRC_INC    = 3'd0,
    PC_SRC_JALR   = 3'd1,
    PC_SRC_BRANCH = 3'd2,
    PC_SRC_JAL    = 3'd3,
    PC_SRC_MTVEC  = 3'd4,
    PC_SRC_MEPC   = 3'd5
  } pc_src_t;

  typedef enum logic [1:0] {
    FS_HOLD,
    FS_FETCH,
    FS_READY
  } fetch_state_t;

  localparam logic [31:0] OTTER_RESET_VECTOR = 32'h0000_0000;

  // Word alignment test used on every candidate PC.
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC source select. JALR targets get bit0 cleared before the
// alignment test; encodings 6 and 7 fall back to the sequential PC.
import otter_pkg::*;

module pc_next_mux (
  input  logic [2:0]  i_sel,
  input  logic [31:0] i_pc_plus4,
  input  logic [31:0] i_jalr,
  input  logic [31:0] i_branch,
  input  logic [31:0] i_jal,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  output logic [31:0] o_target,
  output logic        o_misalign
);

  logic [31:0] w_jalr_masked;

  assign w_jalr_masked = i_jalr & ~32'h0000_0001;

  // Source select; misalignment is judged on the final (masked) target.
  always_comb begin
    o_target = i_pc_plus4;
    case (i_sel)
      PC_SRC_JALR:   o_target = w_jalr_masked;
      PC_SRC_BRANCH: o_target = i_branch;
      PC_SRC_JAL:    o_target = i_jal;
      PC_SRC_MTVEC:  o_target = i_mtvec;
      PC_SRC_MEPC:   o_target = i_mepc;
      default:       o_target = i_pc_plus4;
    endcase
    o_misalign = ~is_aligned(o_target);
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC stage: holds PC, runs a single-outstanding instruction fetch and
// captures the returned word into IR. PC updates only from READY.
import otter_pkg::*;

module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = OTTER_RESET_VECTOR,
  parameter int          PC_INC       = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PC_WRITE,
  input  logic [2:0]  PC_SOURCE,
  input  logic [31:0] JALR,
  input  logic [31:0] BRANCH,
  input  logic [31:0] JAL,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  input  logic        IMEM_VALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic [31:0] IR,
  output logic        IR_VALID,
  output logic        MISALIGN
);

  fetch_state_t r_state, w_next_state;
  logic [31:0]  r_pc, r_ir;
  logic         r_ir_valid, r_misalign;

  logic [31:0]  w_pc_plus4, w_target;
  logic         w_target_mis;
  logic         w_imem_req, w_ir_load, w_pc_load, w_mis_set;

  assign w_pc_plus4 = r_pc + 32'(PC_INC);

  pc_next_mux u_next_mux (
    .i_sel      (PC_SOURCE),
    .i_pc_plus4 (w_pc_plus4),
    .i_jalr     (JALR),
    .i_branch   (BRANCH),
    .i_jal      (JAL),
    .i_mtvec    (MTVEC),
    .i_mepc     (MEPC),
    .o_target   (w_target),
    .o_misalign (w_target_mis)
  );

  // State register; reset parks in HOLD so a stale response is dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= FS_HOLD;
    else     r_state <= w_next_state;
  end

  // Next state plus the per-cycle strobes for PC/IR/MISALIGN updates.
  always_comb begin
    w_next_state = r_state;
    w_imem_req   = 1'b0;
    w_ir_load    = 1'b0;
    w_pc_load    = 1'b0;
    w_mis_set    = 1'b0;
    case (r_state)
      FS_HOLD: w_next_state = FS_FETCH;
      FS_FETCH: begin
        w_imem_req = 1'b1;
        if (IMEM_VALID) begin
          w_ir_load    = 1'b1;
          w_next_state = FS_READY;
        end
      end
      FS_READY: begin
        if (PC_WRITE) begin
          if (w_target_mis) begin
            w_mis_set = 1'b1;
          end else begin
            w_pc_load    = 1'b1;
            w_next_state = FS_FETCH;
          end
        end
      end
      default: w_next_state = FS_HOLD;
    endcase
  end

  // PC register; a rejected (misaligned) target leaves it untouched.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            r_pc <= RESET_VECTOR;
    else if (w_pc_load) r_pc <= w_target;
  end

  // IR capture and validity: set on response, cleared when PC moves.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ir       <= 32'h0;
      r_ir_valid <= 1'b0;
    end else if (w_ir_load) begin
      r_ir       <= IMEM_RDATA;
      r_ir_valid <= 1'b1;
    end else if (w_pc_load) begin
      r_ir_valid <= 1'b0;
    end
  end

  // One-cycle misalign pulse for each rejected PC_WRITE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_misalign <= 1'b0;
    else     r_misalign <= w_mis_set;
  end

  assign IMEM_REQ  = w_imem_req;
  assign IMEM_ADDR = r_pc;
  assign PC        = r_pc;
  assign PC_PLUS4  = w_pc_plus4;
  assign IR        = r_ir;
  assign IR_VALID  = r_ir_valid;
  assign MISALIGN  = r_misalign;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_pc_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PC_WRITE = 1'b0;
  logic [2:0]  PC_SOURCE = 3'd0;
  logic [31:0] JALR = 32'h0, BRANCH = 32'h0, JAL = 32'h0, MTVEC = 32'h0, MEPC = 32'h0;
  logic        IMEM_VALID = 1'b0;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR, PC, PC_PLUS4, IR;
  logic        IR_VALID, MISALIGN;

  int checks = 0;
  int errors = 0;

  pc_fetch_sequencer dut (
    .CLK(CLK), .RST(RST), .PC_WRITE(PC_WRITE), .PC_SOURCE(PC_SOURCE),
    .JALR(JALR), .BRANCH(BRANCH), .JAL(JAL), .MTVEC(MTVEC), .MEPC(MEPC),
    .IMEM_VALID(IMEM_VALID), .IMEM_RDATA(IMEM_RDATA), .IMEM_REQ(IMEM_REQ),
    .IMEM_ADDR(IMEM_ADDR), .PC(PC), .PC_PLUS4(PC_PLUS4), .IR(IR),
    .IR_VALID(IR_VALID), .MISALIGN(MISALIGN)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue a PC_WRITE from READY and take the edge.
  task automatic pc_write(input logic [2:0] src);
    PC_SOURCE = src;
    PC_WRITE  = 1'b1;
    tick();
    PC_WRITE  = 1'b0;
  endtask

  // Complete the outstanding fetch with one response cycle.
  task automatic respond(input logic [31:0] data);
    IMEM_RDATA = data;
    IMEM_VALID = 1'b1;
    tick();
    IMEM_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #3;
    checks++; if (PC !== 32'h0)      begin errors++; $display("FAIL rst_pc got %h exp %h", PC, 32'h0); end
    checks++; if (IR !== 32'h0)      begin errors++; $display("FAIL rst_ir got %h exp %h", IR, 32'h0); end
    checks++; if (IR_VALID !== 1'b0) begin errors++; $display("FAIL rst_irv got %b exp 0", IR_VALID); end
    checks++; if (MISALIGN !== 1'b0) begin errors++; $display("FAIL rst_mis got %b exp 0", MISALIGN); end
    checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", IMEM_REQ); end
    tick();
    RST = 1'b0;
    tick();  // HOLD -> FETCH
    checks++; if (IMEM_REQ !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", IMEM_REQ); end
    checks++; if (IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL first_addr got %h exp %h", IMEM_ADDR, 32'h0); end
    respond(32'h0000_0013);
    checks++; if (IR !== 32'h13)     begin errors++; $display("FAIL first_ir got %h exp %h", IR, 32'h13); end
    checks++; if (IR_VALID !== 1'b1) begin errors++; $display("FAIL first_irv got %b exp 1", IR_VALID); end
    checks++; if (PC !== 32'h0)      begin errors++; $display("FAIL first_pc got %h exp %h", PC, 32'h0); end
    checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL ready_req got %b exp 0", IMEM_REQ); end
    checks++; if (PC_PLUS4 !== 32'h4) begin errors++; $display("FAIL pc_plus4 got %h exp %h", PC_PLUS4, 32'h4); end
  endtask

  task automatic test_jal();
    JAL = 32'h100;
    pc_write(3'd3);
    respond(32'h1111_1111);
    JAL = 32'h200;
    pc_write(3'd3);
    checks++; if (PC !== 32'h200)    begin errors++; $display("FAIL jal_pc got %h exp %h", PC, 32'h200); end
    checks++; if (IR_VALID !== 1'b0) begin errors++; $display("FAIL jal_irv got %b exp 0", IR_VALID); end
    checks++; if (IMEM_REQ !== 1'b1) begin errors++; $display("FAIL jal_req got %b exp 1", IMEM_REQ); end
    checks++; if (IMEM_ADDR !== 32'h200) begin errors++; $display("FAIL jal_addr got %h exp %h", IMEM_ADDR, 32'h200); end
    respond(32'h2222_2222);
    checks++; if (IR !== 32'h2222_2222) begin errors++; $display("FAIL jal_ir got %h exp %h", IR, 32'h2222_2222); end
  endtask

  task automatic test_jalr_misalign();
    JALR = 32'h0000_0305;
    pc_write(3'd1);
    checks++; if (PC !== 32'h304) begin errors++; $display("FAIL jalr_pc got %h exp %h", PC, 32'h304); end
    respond(32'h3333_3333);
    JALR = 32'h0000_0306;
    pc_write(3'd1);
    checks++; if (MISALIGN !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b exp 1", MISALIGN); end
    checks++; if (PC !== 32'h304)    begin errors++; $display("FAIL mis_pc got %h exp %h", PC, 32'h304); end
    checks++; if (IR_VALID !== 1'b1) begin errors++; $display("FAIL mis_irv got %b exp 1", IR_VALID); end
    checks++; if (IR !== 32'h3333_3333) begin errors++; $display("FAIL mis_ir got %h exp %h", IR, 32'h3333_3333); end
    checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL mis_req got %b exp 0", IMEM_REQ); end
    tick();
    checks++; if (MISALIGN !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", MISALIGN); end
    checks++; if (PC !== 32'h304)    begin errors++; $display("FAIL mis_pc2 got %h exp %h", PC, 32'h304); end
  endtask

  task automatic test_sources();
    BRANCH = 32'h0000_0402;
    pc_write(3'd2);
    checks++; if (MISALIGN !== 1'b1 || PC !== 32'h304) begin errors++; $display("FAIL br_mis got mis=%b pc=%h exp mis=1 pc=%h", MISALIGN, PC, 32'h304); end
    BRANCH = 32'h0000_0400;
    pc_write(3'd2);
    checks++; if (PC !== 32'h400) begin errors++; $display("FAIL br_pc got %h exp %h", PC, 32'h400); end
    respond(32'h4);
    MTVEC = 32'h0000_0800;
    pc_write(3'd4);
    checks++; if (PC !== 32'h800) begin errors++; $display("FAIL mtvec_pc got %h exp %h", PC, 32'h800); end
    respond(32'h5);
    MEPC = 32'h0000_1000;
    pc_write(3'd5);
    checks++; if (PC !== 32'h1000) begin errors++; $display("FAIL mepc_pc got %h exp %h", PC, 32'h1000); end
    respond(32'h6);
    pc_write(3'd7);
    checks++; if (PC !== 32'h1004) begin errors++; $display("FAIL src7_pc got %h exp %h", PC, 32'h1004); end
    respond(32'h7);
    // A response outside FETCH must not touch IR.
    respond(32'hBAD0_BAD0);
    checks++; if (IR !== 32'h7) begin errors++; $display("FAIL stray_ir got %h exp %h", IR, 32'h7); end
  endtask

  task automatic test_wrap();
    JAL = 32'hFFFF_FFFC;
    pc_write(3'd3);
    respond(32'h8);
    checks++; if (PC_PLUS4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h exp %h", PC_PLUS4, 32'h0); end
    pc_write(3'd0);
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp %h", PC, 32'h0); end
    respond(32'h9);
  endtask

  task automatic test_fetch_stall();
    JAL = 32'h0000_0500;
    pc_write(3'd3);
    JAL = 32'h0000_0600;
    PC_SOURCE = 3'd3;
    PC_WRITE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (PC !== 32'h500 || IMEM_REQ !== 1'b1 || IR_VALID !== 1'b0)
        begin errors++; $display("FAIL stall_%0d got pc=%h req=%b irv=%b exp pc=%h req=1 irv=0", i, PC, IMEM_REQ, IR_VALID, 32'h500); end
    end
    PC_WRITE = 1'b0;
    respond(32'hA);
    checks++; if (IR !== 32'hA || PC !== 32'h500) begin errors++; $display("FAIL stall_done got ir=%h pc=%h exp ir=%h pc=%h", IR, PC, 32'hA, 32'h500); end
  endtask

  task automatic test_reset_mid_fetch();
    JAL = 32'h0000_0040;
    pc_write(3'd3);
    checks++; if (PC !== 32'h40 || IMEM_REQ !== 1'b1) begin errors++; $display("FAIL mid_setup got pc=%h req=%b exp pc=%h req=1", PC, IMEM_REQ, 32'h40); end
    RST = 1'b1;
    #1;
    checks++; if (PC !== 32'h0 || IMEM_REQ !== 1'b0) begin errors++; $display("FAIL mid_rst got pc=%h req=%b exp pc=%h req=0", PC, IMEM_REQ, 32'h0); end
    tick();
    RST = 1'b0;
    IMEM_RDATA = 32'hDEAD_BEEF;
    IMEM_VALID = 1'b1;
    tick();  // HOLD cycle: response dropped
    IMEM_VALID = 1'b0;
    checks++; if (IR !== 32'h0 || IR_VALID !== 1'b0) begin errors++; $display("FAIL mid_drop got ir=%h irv=%b exp ir=%h irv=0", IR, IR_VALID, 32'h0); end
    checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL mid_refetch got req=%b addr=%h exp req=1 addr=%h", IMEM_REQ, IMEM_ADDR, 32'h0); end
    respond(32'h0000_0013);
    checks++; if (IR !== 32'h13 || IR_VALID !== 1'b1) begin errors++; $display("FAIL mid_ir got ir=%h irv=%b exp ir=%h irv=1", IR, IR_VALID, 32'h13); end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_jalr_misalign();
    test_sources();
    test_wrap();
    test_fetch_stall();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
